cdm16_acc_stage: RTL and testbench
==================================

// Module: cdm16_acc_stage
// PURPOSE
//  Sequential accumulate stage downstream of the 16x16 carry-disregard approximate multiplier.
//  Consumes a burst of LEN 32-bit approximate products over a valid/ready handshake.
//  Sums them into a wide accumulator and presents one result through a valid/ready handshake.
//  Used for dot-product / error-statistics runs of the approximate multiplier datapath.
// PARAMETERS
//  ACC_W  40  accumulator/result width in bits; must be >= 32
//  LEN_W  8   width of burst-length field; max burst = 2^LEN_W-1 products
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      begin a burst; sampled only in IDLE
//  len         in   LEN_W  number of products in burst; sampled with start
//  prod        in   32     unsigned product R[31:0] from the multiplier
//  prod_valid  in   1      prod is valid this cycle
//  prod_ready  out  1      stage accepts prod this cycle
//  res         out  ACC_W  accumulated sum
//  res_valid   out  1      res is valid
//  res_ready   in   1      consumer takes res
//  busy        out  1      high in ACC or DONE
//  ovf         out  1      sticky: sum exceeded 2^ACC_W-1 during current burst
// BEHAVIOUR
//  Reset: async on rst_n=0. State=IDLE; acc, cnt, len_q, ovf=0.
//   Reset outputs: prod_ready=0, res_valid=0, res=0, busy=0, ovf=0.
//   Reset mid-burst aborts the burst; no partial result is produced.
//  FSM has three states: IDLE, ACC, DONE. All outputs are decoded from registered state; no comb path in->out.
//  IDLE:
//   - prod_ready=0.
//   - start=1 latches len into len_q and clears acc, cnt and ovf.
//   - Next state is DONE if len==0, else ACC.
//  ACC:
//   - prod_ready=1. A beat is accepted when prod_valid & prod_ready.
//   - Accepted beat: acc <= acc + {0,prod} (modulo 2^ACC_W); cnt++.
//   - Carry out of bit ACC_W-1 sets ovf.
//   - A beat accepted with cnt==len_q-1 moves the FSM to DONE.
//   - prod_valid=0 cycles stall with no state change.
//  DONE:
//   - res_valid=1; res=acc, held stable until handshake.
//   - res_valid & res_ready -> IDLE next cycle; res_valid drops that cycle.
//  Timing:
//   - Latency: res_valid rises on the cycle after the last accepted beat.
//   - For len==0: res_valid rises 1 cycle after start, with res=0.
//   - Max throughput: 1 product/cycle. Back-to-back bursts need >=1 IDLE cycle between them.
//  start in ACC/DONE: ignored; no effect on len_q or acc.
//  res, ovf in IDLE: keep the last burst's values until the next start clears them.
//  Products are treated as unsigned and zero-extended; the stage applies no approximation.
// TESTING
//  1 Basic burst: len=3, prods 1,2,3 on consecutive cycles.
//     -> res=6, ovf=0; res_valid rises the cycle after 3rd beat.
//  2 Source gaps: len=4, prods 0xFFFF0000 x4 with prod_valid low 2 cycles between beats.
//     -> res=0x3_FFFC_0000; cnt unaffected by gaps.
//  3 Zero length: start with len=0.
//     -> prod_ready never asserted; res_valid=1, res=0 one cycle later.
//  4 Overflow: ACC_W=32, len=2, prods 0xFFFFFFFF, 0x00000002.
//     -> res=0x00000001, ovf=1.
//  5 Sink backpressure: res_ready=0 for 5 cycles in DONE, with start pulsed.
//     -> res stable, state remains DONE, start ignored.
//     -> Accepted on the res_ready=1 cycle.
//  6 Reset mid-burst: rst_n low after 2 of 5 beats.
//     -> All outputs 0 immediately. A new burst len=1, prod=7 -> res=7.

Source files
------------

// File: rtl/cdm16_acc_stage.sv
// Accumulate stage behind the carry-disregard approximate multiplier: sums a burst of
// unsigned 32-bit products into a wide accumulator and hands back one result.
module cdm16_acc_stage #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             ovf,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a beat/result transfers on a rising edge where valid and ready are both high.
  // prod_ready and res_valid are decoded from registered state only, never from inputs.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             ovf_q;
  logic [ACC_W:0]   acc_sum_d;

  // Extra top bit captures the carry out of the accumulator for the sticky overflow flag.
  assign acc_sum_d = {1'b0, acc_q} + (ACC_W + 1)'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q   <= len;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= (len == '0) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (prod_valid) begin
            acc_q <= acc_sum_d[ACC_W-1:0];
            cnt_q <= cnt_q + LEN_W'(1);
            if (acc_sum_d[ACC_W]) ovf_q <= 1'b1;
            if (cnt_q == len_q - LEN_W'(1)) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign prod_ready  = (state_q == S_ACC);
  assign res_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign res         = acc_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cdm16_acc_stage.sv
// Bench for cdm16_acc_stage: directed scenarios plus randomized bursts checked against a
// sum-of-products reference model and an expected-result queue.
module tb_cdm16_acc_stage;

  localparam int ACC_W = 40;
  localparam int LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [31:0]      prod;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] res;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             ovf;
  logic [1:0]       dbg_state;

  logic             start32;
  logic [LEN_W-1:0] len32;
  logic [31:0]      prod32;
  logic             prod_valid32;
  logic             prod_ready32;
  logic [31:0]      res32;
  logic             res_valid32;
  logic             res_ready32;
  logic             busy32;
  logic             ovf32;
  logic [1:0]       dbg_state32;

  int total;
  int bad;

  logic [31:0]      prod_q[$];
  logic [ACC_W-1:0] exp_q[$];
  logic             exp_ovf_q[$];

  cdm16_acc_stage #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .res(res), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .ovf(ovf), .dbg_state_o(dbg_state)
  );

  cdm16_acc_stage #(.ACC_W(32), .LEN_W(LEN_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .len(len32), .prod(prod32),
    .prod_valid(prod_valid32), .prod_ready(prod_ready32), .res(res32), .res_valid(res_valid32),
    .res_ready(res_ready32), .busy(busy32), .ovf(ovf32), .dbg_state_o(dbg_state32)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: true sum of the burst, reduced modulo 2^ACC_W; any wrap means overflow.
  task automatic model_push();
    longint unsigned s;
    s = 0;
    foreach (prod_q[i]) s += 64'(prod_q[i]);
    exp_q.push_back(ACC_W'(s % (64'd1 << ACC_W)));
    exp_ovf_q.push_back((s >> ACC_W) != 0);
  endtask

  // Driver: one full burst from IDLE through result handshake.
  task automatic run_burst(input int gap_max, input int hold_max, input bit poke_start);
    int n;
    int gaps;
    int holds;
    logic [ACC_W-1:0] e_res;
    logic e_ovf;
    n = prod_q.size();
    model_push();
    start = 1'b1;
    len = LEN_W'(n);
    tick();
    start = 1'b0;
    total++;
    if (prod_ready !== (n != 0)) begin
      bad++; $display("FAIL prod_ready_after_start: got %b want %b", prod_ready, (n != 0));
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL busy_after_start: got %b want 1", busy);
    end
    for (int i = 0; i < n; i++) begin
      gaps = $urandom_range(0, gap_max);
      for (int g = 0; g < gaps; g++) begin
        prod_valid = 1'b0;
        prod = $urandom;
        tick();
        total++;
        if (prod_ready !== 1'b1 || res_valid !== 1'b0) begin
          bad++; $display("FAIL gap_stall: got ready=%b valid=%b want 1/0", prod_ready, res_valid);
        end
      end
      prod_valid = 1'b1;
      prod = prod_q[i];
      total++;
      if (prod_ready !== 1'b1) begin
        bad++; $display("FAIL beat_ready: beat %0d got %b want 1", i, prod_ready);
      end
      tick();
      prod_valid = 1'b0;
      if (i < n - 1) begin
        total++;
        if (res_valid !== 1'b0) begin
          bad++; $display("FAIL early_res_valid: beat %0d got %b want 0", i, res_valid);
        end
      end
    end
    e_res = exp_q.pop_front();
    e_ovf = exp_ovf_q.pop_front();
    total++;
    if (res_valid !== 1'b1) begin
      bad++; $display("FAIL res_valid_latency: got %b want 1", res_valid);
    end
    total++;
    if (res !== e_res) begin
      bad++; $display("FAIL res_value: got %h want %h", res, e_res);
    end
    total++;
    if (ovf !== e_ovf) begin
      bad++; $display("FAIL ovf_value: got %b want %b", ovf, e_ovf);
    end
    holds = poke_start ? 5 : $urandom_range(0, hold_max);
    for (int h = 0; h < holds; h++) begin
      res_ready = 1'b0;
      if (poke_start) begin
        start = 1'b1;
        len = LEN_W'($urandom_range(0, 255));
      end
      tick();
      total++;
      if (res !== e_res || res_valid !== 1'b1 || busy !== 1'b1 || prod_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable: got res=%h valid=%b busy=%b ready=%b want %h/1/1/0",
                 res, res_valid, busy, prod_ready, e_res);
      end
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL handshake_idle: got valid=%b busy=%b want 0/0", res_valid, busy);
    end
    total++;
    if (res !== e_res || ovf !== e_ovf) begin
      bad++; $display("FAIL idle_keeps_result: got %h/%b want %h/%b", res, ovf, e_res, e_ovf);
    end
    prod_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; len = '0; prod = '0; prod_valid = 1'b0; res_ready = 1'b0;
    start32 = 1'b0; len32 = '0; prod32 = '0; prod_valid32 = 1'b0; res_ready32 = 1'b0;
    repeat (3) tick();
    total++;
    if (prod_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got ready=%b valid=%b busy=%b ovf=%b want 0", prod_ready, res_valid, busy, ovf);
    end
    total++;
    if (res !== '0) begin
      bad++; $display("FAIL reset_res: got %h want 0", res);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    prod_q = '{32'd1, 32'd2, 32'd3};
    run_burst(0, 0, 1'b0);
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 4; i++) prod_q.push_back(32'hFFFF_0000);
    total++;
    if (ACC_W'(40'h3_FFFC_0000) !== ACC_W'(4 * 64'hFFFF_0000)) begin
      bad++; $display("FAIL gaps_model: got %h want %h", 4 * 64'hFFFF_0000, 40'h3_FFFC_0000);
    end
    // Exactly two idle source cycles between beats.
    model_push();
    begin
      logic [ACC_W-1:0] e;
      logic eo;
      e = exp_q.pop_front();
      eo = exp_ovf_q.pop_front();
      start = 1'b1; len = 8'd4;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (i != 0) begin
          prod_valid = 1'b0;
          repeat (2) tick();
        end
        prod_valid = 1'b1; prod = 32'hFFFF_0000;
        tick();
        prod_valid = 1'b0;
      end
      total++;
      if (res_valid !== 1'b1 || res !== e || ovf !== eo) begin
        bad++; $display("FAIL gaps_result: got %b/%h/%b want 1/%h/%b", res_valid, res, ovf, e, eo);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    prod_q.delete();
  endtask

  task automatic test_zero_len();
    run_burst(0, 1, 1'b0);
  endtask

  task automatic test_overflow();
    longint unsigned s;
    s = 64'hFFFF_FFFF + 64'h2;
    start32 = 1'b1; len32 = 8'd2;
    tick();
    start32 = 1'b0;
    prod_valid32 = 1'b1; prod32 = 32'hFFFF_FFFF;
    tick();
    prod32 = 32'h0000_0002;
    tick();
    prod_valid32 = 1'b0;
    total++;
    if (res_valid32 !== 1'b1 || res32 !== s[31:0]) begin
      bad++; $display("FAIL ovf_res: got %b/%h want 1/%h", res_valid32, res32, s[31:0]);
    end
    total++;
    if (ovf32 !== ((s >> 32) != 0)) begin
      bad++; $display("FAIL ovf_flag: got %b want %b", ovf32, ((s >> 32) != 0));
    end
    res_ready32 = 1'b1;
    tick();
    res_ready32 = 1'b0;
    total++;
    if (ovf32 !== 1'b1 || busy32 !== 1'b0) begin
      bad++; $display("FAIL ovf_sticky_idle: got ovf=%b busy=%b want 1/0", ovf32, busy32);
    end
    start32 = 1'b1; len32 = 8'd1;
    tick();
    start32 = 1'b0;
    total++;
    if (ovf32 !== 1'b0 || res32 !== 32'd0) begin
      bad++; $display("FAIL ovf_clear_on_start: got ovf=%b res=%h want 0/0", ovf32, res32);
    end
    prod_valid32 = 1'b1; prod32 = 32'd5;
    tick();
    prod_valid32 = 1'b0;
    res_ready32 = 1'b1;
    tick();
    res_ready32 = 1'b0;
  endtask

  task automatic test_backpressure();
    prod_q = '{$urandom, $urandom};
    run_burst(1, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    prod_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      prod = $urandom;
      tick();
    end
    prod_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    total++;
    if (prod_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || res !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got ready=%b valid=%b busy=%b ovf=%b res=%h want all 0",
               prod_ready, res_valid, busy, ovf, res);
    end
    tick();
    rst_n = 1'b1;
    tick();
    prod_q = '{32'd7};
    run_burst(0, 0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) prod_q.push_back(32'hFFFF_FFFF - $urandom_range(0, 15));
        else prod_q.push_back($urandom);
      end
      run_burst(2, 3, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      prod_q.push_back($urandom);
      prod_q.push_back($urandom);
      run_burst(0, 0, 1'b0);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
